// File: rtl/vedic_pkg.sv
// Shared types and constants for the iterative 64x64 vedic multiplier.
package vedic_pkg;

    localparam int HALF_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_LH = 2'd1;
    localparam logic [1:0] STEP_HL = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    // Left shift applied to each half-product before accumulation.
    function automatic logic [6:0] step_shift(input logic [1:0] step);
        case (step)
            STEP_LL: step_shift = 7'd0;
            STEP_LH: step_shift = 7'd32;
            STEP_HL: step_shift = 7'd32;
            default: step_shift = 7'd64;
        endcase
    endfunction

    // Lowest unskipped step at or above 'from'; bit 2 of the result flags "found".
    function automatic logic [2:0] next_unskipped(input logic [3:0] skip, input logic [2:0] from);
        next_unskipped = 3'b000;
        for (int s = 3; s >= 0; s--) begin
            if (s >= int'(from) && !skip[s])
                next_unskipped = {1'b1, 2'(s)};
        end
    endfunction

endpackage

// File: rtl/vedic_mul64_seq_if.sv
// Operand/result handshake bundle for vedic_mul64_seq.
interface vedic_mul64_seq_if #(parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      a;
    logic [63:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     y;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, y, busy, op_count);
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, y, busy, op_count);
endinterface

// File: rtl/vedic_mul64_seq_vedic_32x32.sv
// vedic_32x32: combinational 32x32 unsigned multiplier, urdhva-tiryagbhyam
// (vertical and crosswise) composition of four 16x16 partial products.
module vedic_32x32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_p
);
    logic [31:0] w_ll, w_lh, w_hl, w_hh;
    logic [32:0] w_cross;

    assign w_ll    = {16'b0, i_a[15:0]}  * {16'b0, i_b[15:0]};
    assign w_lh    = {16'b0, i_a[15:0]}  * {16'b0, i_b[31:16]};
    assign w_hl    = {16'b0, i_a[31:16]} * {16'b0, i_b[15:0]};
    assign w_hh    = {16'b0, i_a[31:16]} * {16'b0, i_b[31:16]};
    // Crosswise terms share a weight, so sum them before shifting.
    assign w_cross = {1'b0, w_lh} + {1'b0, w_hl};
    assign o_p     = {32'b0, w_ll} + {15'b0, w_cross, 16'b0} + {w_hh, 32'b0};
endmodule

// File: rtl/vedic_mul64_seq.sv
// vedic_mul64_seq: iterative 64x64 unsigned multiplier, one half-product per cycle
// through a single vedic_32x32. Optional macro ZERO_SKIP_EN skips half-products
// whose operand halves are zero (results identical, shorter latency).
module vedic_mul64_seq
    import vedic_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    vedic_mul64_seq_if.slave bus
);
    state_t           r_state;
    logic [63:0]      r_a, r_b;
    logic [127:0]     r_acc;
    logic [1:0]       r_step;
    logic [3:0]       r_skip;
    logic             r_in_ready, r_out_valid, r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]   w_mask;
    logic [2:0]   w_first, w_next;
    logic [31:0]  w_ah, w_bh;
    logic [63:0]  w_prod;
    logic [127:0] w_term;

    // Skip mask is built from the live inputs so it is ready at the accept edge.
`ifdef ZERO_SKIP_EN
    assign w_mask = {(bus.a[63:32] == '0) || (bus.b[63:32] == '0),
                     (bus.a[63:32] == '0) || (bus.b[31:0]  == '0),
                     (bus.a[31:0]  == '0) || (bus.b[63:32] == '0),
                     (bus.a[31:0]  == '0) || (bus.b[31:0]  == '0)};
`else
    assign w_mask = 4'b0000;
`endif

    assign w_first = next_unskipped(w_mask, 3'd0);
    assign w_next  = next_unskipped(r_skip, {1'b0, r_step} + 3'd1);

    // Step bit 1 picks the a-half, bit 0 picks the b-half (LL, LH, HL, HH).
    assign w_ah = r_step[1] ? r_a[63:32] : r_a[31:0];
    assign w_bh = r_step[0] ? r_b[63:32] : r_b[31:0];

    vedic_32x32 u_mul (.i_a(w_ah), .i_b(w_bh), .o_p(w_prod));

    // A skipped step contributes nothing; this also covers the all-skipped dummy cycle.
    assign w_term = r_skip[r_step] ? '0 : ({64'b0, w_prod} << step_shift(r_step));

    // Control FSM, accumulator and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_step      <= STEP_LL;
            r_skip      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_acc      <= '0;
                        r_skip     <= w_mask;
                        r_step     <= w_first[2] ? w_first[1:0] : STEP_LL;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= MUL;
                    end
                end
                MUL: begin
                    r_acc <= r_acc + w_term;
                    if (w_next[2]) begin
                        r_step <= w_next[1:0];
                    end else begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cnt       <= r_cnt + 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_acc;
    assign bus.busy      = r_busy;
    assign bus.op_count  = r_cnt;
endmodule

// File: tb/tb_vedic_mul64_seq.sv
// Self-checking bench for vedic_mul64_seq (CNT_W=4) against a plain a*b model.
module tb_vedic_mul64_seq;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;
    logic [127:0] exp_y = '0;
    logic [3:0]   exp_cnt = '0;

    vedic_mul64_seq_if #(.CNT_W(4)) bus ();
    vedic_mul64_seq #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        return {64'b0, a} * {64'b0, b};
    endfunction

    function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b);
`ifdef ZERO_SKIP_EN
        int n = 0;
        if (a[31:0]  != 0 && b[31:0]  != 0) n++;
        if (a[31:0]  != 0 && b[63:32] != 0) n++;
        if (a[63:32] != 0 && b[31:0]  != 0) n++;
        if (a[63:32] != 0 && b[63:32] != 0) n++;
        return (n == 0) ? 1 : n;
`else
        return 4;
`endif
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model state.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("op_count", 128'(bus.op_count), 128'(exp_cnt));
            chk("no_overlap", 128'(bus.in_ready & bus.out_valid), 128'd0);
            chk("busy", 128'(bus.busy), 128'(!bus.in_ready));
            if (bus.out_valid) chk("y", bus.y, exp_y);
        end
    end

    // One operation: accept, latency check, optional backpressure, handoff.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] want, input int hold);
        int g = 0;
        int lat = 0;
        while (!bus.in_ready && g < 50) begin @(posedge clk); #1; g++; end
        chk("in_ready_wait", 128'(bus.in_ready), 128'd1);
        bus.out_ready = (hold == 0);
        bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        exp_y = want;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
        bus.in_valid = 1'b1; // ignored while busy
        do begin
            lat++;
            if (!bus.out_valid) begin @(posedge clk); #1; end
        end while (!bus.out_valid && lat < 20);
        bus.in_valid = 1'b0;
        chk("latency", 128'(lat), 128'(ref_lat(a, b)));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 4'd1;
        chk("handoff_valid", 128'(bus.out_valid), 128'd0);
        chk("handoff_in_ready", 128'(bus.in_ready), 128'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        exp_cnt = '0;
        #1;
        chk("rst_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_count", 128'(bus.op_count), 128'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] ra, rb;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0;
        #12;
        chk("reset_valid", 128'(bus.out_valid), 128'd0);
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_count", 128'(bus.op_count), 128'd0);
        chk("reset_y", bus.y, 128'd0);
        #10 rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("init_in_ready", 128'(bus.in_ready), 128'd1);

        // Model pinned against hand-computed products.
        chk("model_ff", ref_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF),
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        chk("model_35", ref_mul(64'd3, 64'd5), 128'd15);

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0);
        do_op(64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000, 0);
        do_op(64'h0, 64'h1234, 128'h0, 0);
        do_op(64'h1234, 64'h0, 128'h0, 0);
        do_op(64'hDEAD_BEEF, 64'h1_0000_0000, 128'hDEAD_BEEF_0000_0000, 0);

        // Backpressure.
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        do_op(ra, rb, ref_mul(ra, rb), 10);

        // Reset mid-MUL, after step1 has been accumulated.
        bus.a = 64'hFFFF_0000_1234_5678; bus.b = 64'h9999_8888_7777_6666;
        bus.in_valid = 1'b1;
        exp_y = ref_mul(bus.a, bus.b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        pulse_reset();
        do_op(64'd3, 64'd5, 128'd15, 0);

        // Fresh count, 17 back-to-back random ops: op_count wraps to 1.
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra[31:0]  = '0;
            if ($urandom_range(0, 3) == 0) ra[63:32] = '0;
            if ($urandom_range(0, 3) == 0) rb[31:0]  = '0;
            if ($urandom_range(0, 3) == 0) rb[63:32] = '0;
            do_op(ra, rb, ref_mul(ra, rb), 0);
        end
        chk("wrap_count", 128'(bus.op_count), 128'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
